// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler.
package traffic_pkg;

    // Controller states; encoding 2'd3 is unused and treated as illegal.
    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    // Phase indices on the req/green/yellow vectors.
    localparam logic [1:0] PH_NS  = 2'd0;
    localparam logic [1:0] PH_EW  = 2'd1;
    localparam logic [1:0] PH_NSL = 2'd2;
    localparam logic [1:0] PH_PED = 2'd3;

    // Default sizing and timing, all timing in 1 s ticks.
    localparam int DEF_N_PH     = 4;
    localparam int DEF_CW       = 4;
    localparam int DEF_T_RED    = 1;
    localparam int DEF_T_MINGRN = 4;
    localparam int DEF_T_MAXGRN = 15;
    localparam int DEF_T_YEL    = 3;

    // One-hot lamp mask for a phase index.
    function automatic logic [3:0] ph_onehot(input logic [1:0] ph);
        ph_onehot = 4'b0001 << ph;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_pick.sv
// Round-robin finder: first set pending bit after 'last', wrapping, 'last' itself searched last.
module rr_pick (
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] next,
    output logic       valid
);

    logic [7:0] dbl_s;
    logic [2:0] base_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;

    // Rotate pending so bit 0 is the phase after 'last', then priority-encode.
    always_comb begin
        dbl_s  = {pending, pending};
        base_s = {1'b0, last} + 3'd1;
        rot_s  = dbl_s[base_s +: 4];
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        next  = base_s[1:0] + off_s;
        valid = |pending;
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection scheduler: round-robin green among 4 phases with all-red,
// min/max green and yellow timing counted in tick strobes.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_PH     = DEF_N_PH,
    parameter int CW       = DEF_CW,
    parameter int T_RED    = DEF_T_RED,
    parameter int T_MINGRN = DEF_T_MINGRN,
    parameter int T_MAXGRN = DEF_T_MAXGRN,
    parameter int T_YEL    = DEF_T_YEL
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            tick,
    input  logic [N_PH-1:0] req,
    output logic [N_PH-1:0] green,
    output logic [N_PH-1:0] yellow,
    output logic            all_red,
    output logic [1:0]      cur_ph
);

    localparam int CWP = CW + 1;
    localparam logic [CW-1:0] RED_C    = CW'(T_RED);
    localparam logic [CW:0]   MINGRN_C = CWP'(T_MINGRN);
    localparam logic [CW:0]   MAXGRN_C = CWP'(T_MAXGRN);
    localparam logic [CW:0]   YEL_C    = CWP'(T_YEL);

    state_t          state_r, state_s;
    logic [CW-1:0]   count_r, count_s;
    logic [1:0]      cur_ph_r, cur_ph_s;
    logic [N_PH-1:0] pending_r, pending_s;

    logic [N_PH-1:0] cur_mask_s;
    logic [N_PH-1:0] other_s;
    logic [CW:0]     count_inc_s;
    logic [1:0]      pick_s;
    logic            pick_valid_s;

    assign cur_mask_s  = ph_onehot(cur_ph_r);
    assign other_s     = pending_r & ~cur_mask_s;
    assign count_inc_s = {1'b0, count_r} + CWP'(1);

    rr_pick u_rr_pick (
        .pending (pending_r),
        .last    (cur_ph_r),
        .next    (pick_s),
        .valid   (pick_valid_s)
    );

    // State, timer, served phase and latched demand registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r   <= ALLRED;
            count_r   <= '0;
            cur_ph_r  <= PH_PED;
            pending_r <= '0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            cur_ph_r  <= cur_ph_s;
            pending_r <= pending_s;
        end
    end

    // Next-state, timer and demand latching; the served phase never re-latches its own request.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        cur_ph_s  = cur_ph_r;
        pending_s = pending_r | (req & ~((state_r == GREEN) ? cur_mask_s : '0));
        case (state_r)
            ALLRED: begin
                if ((count_r >= RED_C) && pick_valid_s) begin
                    state_s   = GREEN;
                    count_s   = '0;
                    cur_ph_s  = pick_s;
                    pending_s = pending_s & ~ph_onehot(pick_s);
                end else if (tick && (count_r < RED_C)) begin
                    count_s = count_r + CW'(1);
                end else begin
                    count_s = count_r;
                end
            end
            GREEN: begin
                if (tick) begin
                    if ((count_inc_s >= MINGRN_C) && (other_s != '0) &&
                        (!req[cur_ph_r] || (count_inc_s >= MAXGRN_C))) begin
                        state_s = YELLOW;
                        count_s = '0;
                    end else if (count_inc_s <= MAXGRN_C) begin
                        count_s = count_inc_s[CW-1:0];
                    end else begin
                        count_s = count_r;
                    end
                end else begin
                    count_s = count_r;
                end
            end
            YELLOW: begin
                if (tick) begin
                    if (count_inc_s == YEL_C) begin
                        state_s = ALLRED;
                        count_s = '0;
                    end else begin
                        count_s = count_inc_s[CW-1:0];
                    end
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                state_s = ALLRED;
                count_s = '0;
            end
        endcase
    end

    // Lamp decode from the registered state and served phase.
    always_comb begin
        green  = '0;
        yellow = '0;
        case (state_r)
            GREEN:   green  = cur_mask_s;
            YELLOW:  yellow = cur_mask_s;
            default: begin
                green  = '0;
                yellow = '0;
            end
        endcase
        all_red = ~|(green | yellow);
    end

    assign cur_ph = cur_ph_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: interval-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed grant orders and durations.
module tb_traffic_phase_scheduler;

    localparam int T_RED    = 1;
    localparam int T_MINGRN = 4;
    localparam int T_MAXGRN = 15;
    localparam int T_YEL    = 3;
    localparam int TPER     = 4;

    localparam logic [1:0] M_RED = 2'd0;
    localparam logic [1:0] M_GRN = 2'd1;
    localparam logic [1:0] M_YEL = 2'd2;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] green, yellow;
    logic       all_red;
    logic [1:0] cur_ph;

    int n_chk = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .N_PH(4), .CW(4), .T_RED(T_RED), .T_MINGRN(T_MINGRN),
        .T_MAXGRN(T_MAXGRN), .T_YEL(T_YEL)
    ) dut (
        .clk(clk), .clr_n(clr_n), .tick(tick), .req(req),
        .green(green), .yellow(yellow), .all_red(all_red), .cur_ph(cur_ph)
    );

    // Model: which interval we are in, ticks elapsed in it, served phase, waiting demand.
    typedef struct packed {
        logic [1:0] mode;
        int         ticks;
        logic [1:0] ph;
        logic [3:0] pend;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mreset();
        mdl_t r;
        r.mode = M_RED; r.ticks = 0; r.ph = 2'd3; r.pend = 4'b0000;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t cur, logic [3:0] r, logic t);
        mdl_t n = cur;
        bit   other;
        int   el;
        int   p;
        for (int i = 0; i < 4; i++)
            if (r[i] && !(cur.mode == M_GRN && i == int'(cur.ph))) n.pend[i] = 1'b1;
        other = 1'b0;
        for (int i = 0; i < 4; i++)
            if (cur.pend[i] && i != int'(cur.ph)) other = 1'b1;
        if (cur.mode == M_RED) begin
            if (cur.ticks >= T_RED && cur.pend != 4'b0000) begin
                p = -1;
                for (int k = 1; k <= 4; k++)
                    if (p < 0 && cur.pend[(int'(cur.ph) + k) % 4]) p = (int'(cur.ph) + k) % 4;
                n.mode = M_GRN; n.ticks = 0; n.ph = p[1:0]; n.pend[p] = 1'b0;
            end else if (t) begin
                n.ticks = cur.ticks + 1;
            end
        end else if (cur.mode == M_GRN) begin
            if (t) begin
                el = cur.ticks + 1;
                if (el >= T_MINGRN && other && (!r[cur.ph] || el >= T_MAXGRN)) begin
                    n.mode = M_YEL; n.ticks = 0;
                end else begin
                    n.ticks = el;
                end
            end
        end else begin
            if (t) begin
                el = cur.ticks + 1;
                if (el >= T_YEL) begin
                    n.mode = M_RED; n.ticks = 0;
                end else begin
                    n.ticks = el;
                end
            end
        end
        return n;
    endfunction

    // Advance the model with the same inputs the DUT samples.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) m <= mreset();
        else        m <= mstep(m, req, tick);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare DUT lamps and phase against the model every cycle.
    always @(negedge clk) begin
        logic [3:0] eg, ey, one;
        if (check_en) begin
            one = 4'b0001;
            eg = (m.mode == M_GRN) ? (one << m.ph) : 4'b0000;
            ey = (m.mode == M_YEL) ? (one << m.ph) : 4'b0000;
            chk("model_green", {28'd0, green}, {28'd0, eg});
            chk("model_yellow", {28'd0, yellow}, {28'd0, ey});
            chk("model_all_red", {31'd0, all_red}, {31'd0, (eg == 4'b0000 && ey == 4'b0000)});
            chk("model_cur_ph", {30'd0, cur_ph}, {30'd0, m.ph});
        end
    end

    // Interval recording from the lamps.
    int tphase = 0;
    bit tick_en = 1'b1;
    int gcnt, ycnt, rcnt;
    logic [3:0] prev_green, prev_yellow;
    int grants[$];
    int glens[$];
    int ylens[$];
    int rlens[$];

    task automatic clear_rec();
        grants.delete(); glens.delete(); ylens.delete(); rlens.delete();
        gcnt = 0; ycnt = 0; rcnt = 0;
        prev_green = green; prev_yellow = yellow;
        tphase = 0;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            tick = tick_en && (tphase == TPER - 1);
            tphase = (tphase + 1) % TPER;
            if (tick) begin
                if (green != 4'b0000) gcnt++;
                if (yellow != 4'b0000) ycnt++;
                if (all_red) rcnt++;
            end
            @(negedge clk);
            if (prev_green == 4'b0000 && green != 4'b0000) begin
                grants.push_back(int'(cur_ph)); rlens.push_back(rcnt); rcnt = 0;
            end
            if (prev_green != 4'b0000 && green == 4'b0000) begin
                glens.push_back(gcnt); gcnt = 0;
            end
            if (prev_yellow != 4'b0000 && yellow == 4'b0000) begin
                ylens.push_back(ycnt); ycnt = 0;
            end
            prev_green = green;
            prev_yellow = yellow;
        end
    endtask

    task automatic do_reset(input logic [3:0] r);
        clr_n = 1'b0;
        req = r;
        cyc(3);
        chk("rst_green", {28'd0, green}, 32'd0);
        chk("rst_yellow", {28'd0, yellow}, 32'd0);
        chk("rst_all_red", {31'd0, all_red}, 32'd1);
        chk("rst_cur_ph", {30'd0, cur_ph}, 32'd3);
        clr_n = 1'b1;
        clear_rec();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (grants.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk("grant_wait", {31'd0, grants.size() >= n}, 32'd1);
    endtask

    initial begin
        int exp_ord[5];
        int k;
        exp_ord = '{0, 1, 2, 3, 0};

        // Idle: no demand, reset reasserted and released mid-run.
        do_reset(4'b0000);
        check_en = 1'b1;
        clr_n = 1'b0;
        cyc(30);
        clr_n = 1'b1;
        cyc(50);
        chk("s1_all_red", {31'd0, all_red}, 32'd1);
        chk("s1_green", {28'd0, green}, 32'd0);
        chk("s1_no_grant", grants.size(), 32'd0);

        // Single request pulse on phase 1: one all-red tick, then rest in green.
        do_reset(4'b0000);
        req = 4'b0010;
        cyc(1);
        req = 4'b0000;
        wait_grants(1, 100);
        chk("s2_green", {28'd0, green}, 32'h2);
        chk("s2_cur_ph", {30'd0, cur_ph}, 32'd1);
        chk("s2_red_ticks", rlens[0], 32'd1);
        chk("s2_pending", {28'd0, dut.pending_r}, 32'd0);
        cyc(100);
        chk("s2_rest_green", {28'd0, green}, 32'h2);
        chk("s2_one_grant", grants.size(), 32'd1);

        // Full contention: round-robin order with max green, yellow and all-red lengths.
        do_reset(4'b1111);
        wait_grants(5, 1500);
        for (int i = 0; i < 5; i++) chk("s3_order", grants[i], exp_ord[i]);
        for (int i = 0; i < 4; i++) chk("s3_green_len", glens[i], 32'd15);
        for (int i = 0; i < 4; i++) chk("s3_yel_len", ylens[i], 32'd3);
        for (int i = 0; i < 5; i++) chk("s3_red_len", rlens[i], 32'd1);

        // Own demand dropped with competing demand: minimum green only.
        do_reset(4'b0001);
        wait_grants(1, 100);
        chk("s4_first", grants[0], 32'd0);
        req = 4'b0100;
        wait_grants(2, 400);
        chk("s4_min_green", glens[0], 32'd4);
        chk("s4_next", grants[1], 32'd2);
        chk("s4_yel_len", ylens[0], 32'd3);

        // Timebase stall during yellow freezes the yellow interval.
        do_reset(4'b0001);
        wait_grants(1, 100);
        req = 4'b0010;
        k = 0;
        while (yellow == 4'b0000 && k < 200) begin
            cyc(1);
            k++;
        end
        chk("s5_yellow_on", {28'd0, yellow}, 32'h1);
        cyc(4);
        tick_en = 1'b0;
        cyc(50);
        chk("s5_yellow_held", {28'd0, yellow}, 32'h1);
        chk("s5_count_frozen", {28'd0, dut.count_r}, 32'd1);
        chk("s5_ticks_so_far", ycnt, 32'd1);
        tick_en = 1'b1;
        k = 0;
        while (ylens.size() < 1 && k < 100) begin
            cyc(1);
            k++;
        end
        chk("s5_yel_len", ylens[0], 32'd3);

        // Reset during green of phase 2 clears at once; service restarts from phase 0 side.
        do_reset(4'b0100);
        wait_grants(1, 100);
        chk("s6_cur_ph", {30'd0, cur_ph}, 32'd2);
        req = 4'b1010;
        cyc(10);
        chk("s6_green_pre", {28'd0, green}, 32'h4);
        #2;
        clr_n = 1'b0;
        #1;
        chk("s6_rst_green", {28'd0, green}, 32'd0);
        chk("s6_rst_yellow", {28'd0, yellow}, 32'd0);
        chk("s6_rst_all_red", {31'd0, all_red}, 32'd1);
        chk("s6_rst_cur_ph", {30'd0, cur_ph}, 32'd3);
        @(negedge clk);
        cyc(3);
        clr_n = 1'b1;
        clear_rec();
        wait_grants(1, 100);
        chk("s6_restart", grants[0], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Multi-phase intersection scheduler. Shares the single green right-of-way between 4 requesting phases (0=NS through, 1=EW through, 2=NS left, 3=pedestrian) using round-robin.
- Enforces all-red, minimum-green, maximum-green and yellow timing, all counted in 1 s ticks.
- Sits above the per-approach lamp drivers. Requests come from vehicle/ped detectors; one-hot green/yellow outputs drive the lamps.

Parameters:
- N_PH, 4, number of phases (fixed at 4 for this revision)
- CW, 4, timer width in bits
- T_RED, 1, all-red clearance in ticks (>=1)
- T_MINGRN, 4, minimum green in ticks (>=1)
- T_MAXGRN, 15, maximum green in ticks when other demand exists (>=T_MINGRN, <2^CW)
- T_YEL, 3, yellow in ticks (>=1)

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  reset, asynchronous assert, active-low
- tick  in  1  one-cycle timebase strobe (1 s); timers advance only when high
- req  in  N_PH  level demand per phase from detectors
- green  out  N_PH  one-hot green phase, or all zero
- yellow  out  N_PH  one-hot yellow phase, or all zero
- all_red  out  1  high when no phase is green or yellow
- cur_ph  out  2  index of the last/current served phase

Behaviour:
- Reset (clr_n=0, async): state=ALLRED, count=0, cur_ph=3 (so phase 0 is first in round-robin), pending=0, green=0, yellow=0, all_red=1.
- Outputs are a combinational decode of the registered state and cur_ph. They change in the same cycle the state register changes.
- pending[i] is sticky. It is set in any cycle where req[i]=1, except when i==cur_ph and state==GREEN. It is cleared on the clock edge that enters GREEN for phase i. If req[i] is high on that same edge, clear wins.
- State ALLRED:
  - On tick, count++ (saturates at T_RED).
  - Once count>=T_RED and pending!=0, on the next clock (tick not required) go to GREEN with count=0.
  - The chosen phase is the first set pending bit searching cur_ph+1, cur_ph+2, ... with wrap mod 4, including cur_ph itself last.
  - If pending==0, rest in ALLRED.
- State GREEN (phase cur_ph): on tick, count++ saturating at T_MAXGRN. Exit is evaluated on tick cycles using c=count+1:
  - other = pending with cur_ph bit masked.
  - If c>=T_MINGRN and other!=0 and (req[cur_ph]==0 or c>=T_MAXGRN): go to YELLOW, count=0.
  - If other==0: remain green indefinitely (rest in green). Max green applies only when other demand exists.
- State YELLOW: on tick, count++. When count+1==T_YEL on a tick, go to ALLRED with count=0.
- Green duration is always in [T_MINGRN, T_MAXGRN] ticks when contended. Yellow is exactly T_YEL ticks. All-red is at least T_RED ticks.
- tick held low freezes all timers. Requests still latch into pending.
- Never more than one bit set across green|yellow. all_red = ~|(green|yellow).
- Reset mid-cycle (any state) returns immediately to the reset values above. No yellow is emitted on reset.
- Illegal state encoding: recover to ALLRED with count=0.

Decomposition:
- Shared package traffic_pkg holds:
  - state enum/localparams ALLRED=2'd0, GREEN=2'd1, YELLOW=2'd2
  - phase index constants PH_NS=0, PH_EW=1, PH_NSL=2, PH_PED=3
  - default timing constants
- One sub-module, rr_pick: combinational round-robin finder. Inputs pending[3:0] and last[1:0]; outputs next[1:0] and valid.

Test Plan:
- Reset, then req=4'b0000 for 20 ticks -> all_red=1, green=0 throughout; release clr_n mid-run, no glitch on green.
- Reset, pulse req[1] for 1 cycle (tick every 4 clks) -> after 1 tick of all-red, green=4'b0010. It rests green while no other demand; pending[1]=0.
- req=4'b1111 held from reset -> grant order: 0, 1, 2, 3, 0. Each green lasts 15 ticks (own req held, other demand present). Each yellow lasts 3 ticks, each all-red 1 tick.
- Phase 0 green, req[0] dropped at tick 1, req[2] raised -> yellow starts after exactly 4 green ticks (min green), then phase 2 green.
- tick held low for 50 clocks during YELLOW -> yellow unchanged, count frozen. Resuming ticks finishes the remaining yellow ticks exactly.
- clr_n asserted during GREEN of phase 2 -> immediately green=0, all_red=1, cur_ph=3. The next served phase is the lowest pending from 0.
